// File: rtl/gol_pkg.sv
// Shared Game of Life definitions.
// - field_sel_t : which of the two field buffers is selected (shared with the
//                 simulation controller and the display reader).
// - VGA_*       : default 640x480 raster timing (pixels / lines).
// - min_u       : helper for deriving visible field extents.
package gol_pkg;

  typedef enum logic {
    FIELD_A = 1'b0,
    FIELD_B = 1'b1
  } field_sel_t;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster timing generator.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   i_pix_en       : pixel tick; counters advance only when high
//   o_h_cnt/o_v_cnt: current raster position
//   o_line_end     : h_cnt is at the last pixel of the line
//   o_frame_end    : h_cnt and v_cnt are both at their last value
//   o_wrap         : tick on which the counters wrap to (0,0)
//   o_hsync_raw    : unregistered horizontal sync (active-low)
//   o_vsync_raw    : unregistered vertical sync (active-low)
//   o_de_raw       : unregistered active-video flag
//   o_vblank       : v_cnt is in the vertical blanking interval
module vga_timing
  import gol_pkg::*;
#(
  parameter  int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter  int unsigned H_FP     = VGA_H_FP,
  parameter  int unsigned H_SYNC   = VGA_H_SYNC,
  parameter  int unsigned H_BP     = VGA_H_BP,
  parameter  int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter  int unsigned V_FP     = VGA_V_FP,
  parameter  int unsigned V_SYNC   = VGA_V_SYNC,
  parameter  int unsigned V_BP     = VGA_V_BP,
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned H_CNT_W  = $clog2(H_TOTAL),
  localparam int unsigned V_CNT_W  = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_pix_en,
  output logic [H_CNT_W-1:0] o_h_cnt,
  output logic [V_CNT_W-1:0] o_v_cnt,
  output logic               o_line_end,
  output logic               o_frame_end,
  output logic               o_wrap,
  output logic               o_hsync_raw,
  output logic               o_vsync_raw,
  output logic               o_de_raw,
  output logic               o_vblank
);

  logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d;
  int unsigned        h_ext, v_ext;

  // Compare in 32 bits so sync boundaries equal to the total never truncate.
  assign h_ext = 32'(h_cnt_q);
  assign v_ext = 32'(v_cnt_q);

  assign o_line_end  = (h_ext == H_TOTAL - 1);
  assign o_frame_end = o_line_end && (v_ext == V_TOTAL - 1);
  assign o_wrap      = i_pix_en && o_frame_end;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (i_pix_en) begin
      if (o_line_end) begin
        h_cnt_d = '0;
        if (o_frame_end) v_cnt_d = '0;
        else             v_cnt_d = v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign o_h_cnt     = h_cnt_q;
  assign o_v_cnt     = v_cnt_q;
  assign o_hsync_raw = !((h_ext >= H_ACTIVE + H_FP) && (h_ext < H_ACTIVE + H_FP + H_SYNC));
  assign o_vsync_raw = !((v_ext >= V_ACTIVE + V_FP) && (v_ext < V_ACTIVE + V_FP + V_SYNC));
  assign o_de_raw    = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
  assign o_vblank    = (v_ext >= V_ACTIVE);

endmodule

// File: rtl/field_display.sv
// Scan-out reader for the Game of Life field buffers.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_pix_en        : pixel tick; all raster state advances only when high
//   i_read_field    : controller's current stable field
//   o_rd_field      : field displayed this frame (latched at frame wrap)
//   o_cell_x/y      : cell address into the field RAM (0 outside the field)
//   i_cell_state    : cell value read back, valid one clk after the address
//   o_hsync/o_vsync : active-low syncs
//   o_de            : active video
//   o_pixel         : live cell pixel
//   o_vblank        : vertical blanking (unpipelined)
//   o_frame_start   : one-clk pulse on the tick the raster wraps to (0,0)
module field_display
  import gol_pkg::*;
#(
  parameter  int unsigned FIELD_W    = 64,
  parameter  int unsigned FIELD_H    = 48,
  parameter  int unsigned CELL_PX    = 10,
  parameter  int unsigned H_ACTIVE   = VGA_H_ACTIVE,
  parameter  int unsigned H_FP       = VGA_H_FP,
  parameter  int unsigned H_SYNC     = VGA_H_SYNC,
  parameter  int unsigned H_BP       = VGA_H_BP,
  parameter  int unsigned V_ACTIVE   = VGA_V_ACTIVE,
  parameter  int unsigned V_FP       = VGA_V_FP,
  parameter  int unsigned V_SYNC     = VGA_V_SYNC,
  parameter  int unsigned V_BP       = VGA_V_BP,
  localparam int unsigned X_ADR_SIZE = $clog2(FIELD_W),
  localparam int unsigned Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pix_en,
  input  logic                  i_read_field,
  output logic                  o_rd_field,
  output logic [X_ADR_SIZE-1:0] o_cell_x,
  output logic [Y_ADR_SIZE-1:0] o_cell_y,
  input  logic                  i_cell_state,
  output logic                  o_hsync,
  output logic                  o_vsync,
  output logic                  o_de,
  output logic                  o_pixel,
  output logic                  o_vblank,
  output logic                  o_frame_start
);

  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_CNT_W    = $clog2(H_TOTAL);
  localparam int unsigned V_CNT_W    = $clog2(V_TOTAL);
  localparam int unsigned SUB_W      = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam int unsigned FIELD_PX_W = min_u(H_ACTIVE, FIELD_W * CELL_PX);
  localparam int unsigned FIELD_PX_H = min_u(V_ACTIVE, FIELD_H * CELL_PX);

  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;
  logic line_end, frame_end, wrap;
  logic hsync_raw, vsync_raw, de_raw, in_field;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .i_pix_en    (i_pix_en),
    .o_h_cnt     (h_cnt),
    .o_v_cnt     (v_cnt),
    .o_line_end  (line_end),
    .o_frame_end (frame_end),
    .o_wrap      (wrap),
    .o_hsync_raw (hsync_raw),
    .o_vsync_raw (vsync_raw),
    .o_de_raw    (de_raw),
    .o_vblank    (o_vblank)
  );

  assign in_field = (32'(h_cnt) < FIELD_PX_W) && (32'(v_cnt) < FIELD_PX_H);

  // Cell addressing: sub-pixel counters replace a divide by CELL_PX.
  // cell_x/cell_y saturate at the last cell so they never alias past the field.
  logic [SUB_W-1:0]      px_sub_q, px_sub_d, line_sub_q, line_sub_d;
  logic [X_ADR_SIZE-1:0] cx_q, cx_d;
  logic [Y_ADR_SIZE-1:0] cy_q, cy_d;

  always_comb begin
    px_sub_d   = px_sub_q;
    line_sub_d = line_sub_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    if (i_pix_en) begin
      if (line_end) begin
        px_sub_d = '0;
        cx_d     = '0;
        if (frame_end) begin
          line_sub_d = '0;
          cy_d       = '0;
        end else if (32'(line_sub_q) == CELL_PX - 1) begin
          line_sub_d = '0;
          if (32'(cy_q) != FIELD_H - 1) cy_d = cy_q + 1'b1;
        end else begin
          line_sub_d = line_sub_q + 1'b1;
        end
      end else if (32'(px_sub_q) == CELL_PX - 1) begin
        px_sub_d = '0;
        if (32'(cx_q) != FIELD_W - 1) cx_d = cx_q + 1'b1;
      end else begin
        px_sub_d = px_sub_q + 1'b1;
      end
    end
  end

  // S1 also registers the RAM address so it stays stable for a full pixel
  // period and lines up with de/in_field when S2 samples i_cell_state.
  logic                  hsync_s1_q, hsync_s1_d, vsync_s1_q, vsync_s1_d;
  logic                  de_s1_q, de_s1_d, in_field_s1_q, in_field_s1_d;
  logic [X_ADR_SIZE-1:0] cell_x_q, cell_x_d;
  logic [Y_ADR_SIZE-1:0] cell_y_q, cell_y_d;
  logic                  hsync_q, hsync_d, vsync_q, vsync_d;
  logic                  de_q, de_d, pixel_q, pixel_d;
  field_sel_t            rd_field_q, rd_field_d;
  logic                  frame_start_q, frame_start_d;

  always_comb begin
    hsync_s1_d    = hsync_s1_q;
    vsync_s1_d    = vsync_s1_q;
    de_s1_d       = de_s1_q;
    in_field_s1_d = in_field_s1_q;
    cell_x_d      = cell_x_q;
    cell_y_d      = cell_y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    pixel_d       = pixel_q;
    rd_field_d    = rd_field_q;
    frame_start_d = wrap;
    if (i_pix_en) begin
      hsync_s1_d    = hsync_raw;
      vsync_s1_d    = vsync_raw;
      de_s1_d       = de_raw;
      in_field_s1_d = in_field;
      cell_x_d      = in_field ? cx_q : '0;
      cell_y_d      = in_field ? cy_q : '0;
      hsync_d       = hsync_s1_q;
      vsync_d       = vsync_s1_q;
      de_d          = de_s1_q;
      pixel_d       = de_s1_q & in_field_s1_q & i_cell_state;
    end
    if (wrap) rd_field_d = field_sel_t'(i_read_field);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_sub_q      <= '0;
      line_sub_q    <= '0;
      cx_q          <= '0;
      cy_q          <= '0;
      hsync_s1_q    <= 1'b1;
      vsync_s1_q    <= 1'b1;
      de_s1_q       <= 1'b0;
      in_field_s1_q <= 1'b0;
      cell_x_q      <= '0;
      cell_y_q      <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      pixel_q       <= 1'b0;
      rd_field_q    <= FIELD_A;
      frame_start_q <= 1'b0;
    end else begin
      px_sub_q      <= px_sub_d;
      line_sub_q    <= line_sub_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      hsync_s1_q    <= hsync_s1_d;
      vsync_s1_q    <= vsync_s1_d;
      de_s1_q       <= de_s1_d;
      in_field_s1_q <= in_field_s1_d;
      cell_x_q      <= cell_x_d;
      cell_y_q      <= cell_y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      pixel_q       <= pixel_d;
      rd_field_q    <= rd_field_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_rd_field    = rd_field_q;
  assign o_cell_x      = cell_x_q;
  assign o_cell_y      = cell_y_q;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_de          = de_q;
  assign o_pixel       = pixel_q;
  assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_field_display.sv
// Self-checking bench for field_display in a small raster configuration
// (14x11 total, 10x8 active, 4x3 field of 2x2-pixel cells).
module tb_field_display;

  localparam int HT = 14;
  localparam int VT = 11;

  logic       clk = 1'b0;
  logic       rst, pix_en, read_field, cell_state;
  logic       rd_field, hsync, vsync, de, pixel, vblank, frame_start;
  logic [1:0] cell_x, cell_y;

  always #5 clk = ~clk;

  field_display #(
    .FIELD_W (4), .FIELD_H (3), .CELL_PX (2),
    .H_ACTIVE(10), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_pix_en     (pix_en),
    .i_read_field (read_field),
    .o_rd_field   (rd_field),
    .o_cell_x     (cell_x),
    .o_cell_y     (cell_y),
    .i_cell_state (cell_state),
    .o_hsync      (hsync),
    .o_vsync      (vsync),
    .o_de         (de),
    .o_pixel      (pixel),
    .o_vblank     (vblank),
    .o_frame_start(frame_start)
  );

  // Field RAM model: FIELD_A checkerboard, FIELD_B its inverse; 1 clk read latency.
  logic mem [2][4][4];
  always @(posedge clk) cell_state <= mem[rd_field][cell_y][cell_x];

  typedef struct packed {logic hs; logic vs; logic de; logic pix;} exp_t;
  exp_t q[$];

  int   n_cmp = 0, n_bad = 0;
  int   mh, mv, tick_idx, last_fs;
  logic mfield;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (tick %0d)", tag, obs, exp, tick_idx);
    end
  endtask

  task automatic tick();
    exp_t e, o;
    logic inf, last;
    int   ex, ey;
    @(negedge clk);
    pix_en = 1'b1;
    inf   = (mh < 8) && (mv < 6);
    e.hs  = !(mh >= 11 && mh < 13);
    e.vs  = (mv != 9);
    e.de  = (mh < 10) && (mv < 8);
    e.pix = inf ? mem[mfield][mv/2][mh/2] : 1'b0;
    ex    = inf ? mh / 2 : 0;
    ey    = inf ? mv / 2 : 0;
    last  = (mh == HT - 1) && (mv == VT - 1);
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    if (last) mfield = read_field;
    q.push_back(e);
    @(posedge clk);
    #1;
    tick_idx++;
    check("cell_x", 16'(cell_x), 16'(ex));
    check("cell_y", 16'(cell_y), 16'(ey));
    check("frame_start", 16'(frame_start), 16'(last));
    check("vblank", 16'(vblank), 16'(mv >= 8));
    check("rd_field", 16'(rd_field), 16'(mfield));
    if (q.size() == 2) begin
      e = q.pop_front();
      o = '{hs: hsync, vs: vsync, de: de, pix: pixel};
      check("video{hs,vs,de,pix}", 16'(o), 16'(e));
    end
    if (frame_start) begin
      check("frame_period", 16'(tick_idx - last_fs), 16'(HT * VT));
      last_fs = tick_idx;
    end
    @(negedge clk);
    pix_en = 1'b0;
    @(posedge clk);
    #1;
    check("frame_start_idle", 16'(frame_start), 16'd0);
  endtask

  task automatic check_reset_values();
    check("rst_outputs", 16'({hsync, vsync, de, pixel, frame_start, rd_field, vblank, cell_x, cell_y}),
          16'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}));
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; mfield = 1'b0;
    q.delete();
    last_fs = tick_idx;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] snap;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        mem[0][y][x] = (y < 3) ? (((x + y) % 2) == 1) : 1'b0;
        mem[1][y][x] = (y < 3) ? (((x + y) % 2) == 0) : 1'b0;
      end
    tick_idx   = 0;
    rst        = 1'b1;
    pix_en     = 1'b0;
    read_field = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Frame 0 (FIELD_A), then frame 1 with a mid-frame field request.
    repeat (HT * VT) tick();
    repeat (40) tick();
    read_field = 1'b1;
    repeat (HT * VT - 40) tick();

    // Frame 2 shows FIELD_B; freeze the raster mid-line.
    repeat (60) tick();
    snap = 16'({hsync, vsync, de, pixel, vblank, rd_field, cell_x, cell_y});
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("frozen_outputs", 16'({hsync, vsync, de, pixel, vblank, rd_field, cell_x, cell_y}), snap);
      check("frozen_frame_start", 16'(frame_start), 16'd0);
    end

    // Advance to h=5, v=3, then reset asynchronously for 3 clk.
    for (int i = 0; i < 2 * HT * VT && !(mh == 5 && mv == 3); i++) tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_reset_values();
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (HT * VT + 6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
